scan_sel_seq: RTL and testbench
===============================

Name: scan_sel_seq

Overview:
Upstream sequencer for dec_2x4. It generates the 2-bit select (a, b) and the active-low enable (en) that scan the decoder's four active-low outputs round-robin. Each output gets a programmable dwell time. A blanking gap keeps en high while the address changes, so no intermediate code glitches on the decoder outputs. Typical use: multiplexed 4-digit display or 4-row strobe.

Parameters:
- PRESCALE, 4, clk cycles per digit dwell (en=0); legal >=1
- BLANK_CYC, 1, clk cycles en=1 between digits; legal >=0 (0 = no gap)

Ports:
- clk, input, 1, system clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- run, input, 1, 1 = scanning enabled; 0 = stop and disable decoder
- digit_mask, input, 4, bit i = 1 means digit i is included in the scan
- a, output, 1, select MSB to decoder (digit index = {a,b})
- b, output, 1, select LSB to decoder
- en, output, 1, active-low decoder enable (0 = decoder drives one output low)
- tick, output, 1, one-cycle pulse on the first cycle of each new dwell
- cur_dig, output, 2, current digit index, equal to {a,b}

Behaviour:
- All outputs are registered. Reset (async, rst_n=0): a=0, b=0, en=1, tick=0, cur_dig=0, state IDLE, counter 0.
- FSM states:
  - IDLE: en=1; outputs hold.
  - DWELL: en=0 for PRESCALE cycles.
  - BLANK: en=1 for BLANK_CYC cycles.
- IDLE -> DWELL:
  - Condition: run=1 and digit_mask!=0 sampled at edge k.
  - Index loads the lowest set mask bit.
  - From edge k: en=0 and tick=1 for one cycle.
  - Latency: 1 clk from run.
- DWELL:
  - Counter counts 0..PRESCALE-1.
  - At the last count with BLANK_CYC>0: go to BLANK, en=1, and load the next index in the same edge. The address changes only while en=1.
  - At the last count with BLANK_CYC=0: load the next index and stay in DWELL. en stays 0 and tick pulses.
- BLANK: after BLANK_CYC cycles, go to DWELL with en=0 and tick=1.
- Next index: the next set bit of digit_mask strictly after the current index, ascending, wrapping 3->0. If only the current bit is set, the same index is reused; the blank and tick still occur.
- digit_mask is sampled only at next-index selection. A mask change mid-dwell takes effect at the next boundary.
- If the mask is 0 at selection: go to IDLE, en=1, a and b hold.
- run=0 in any state: IDLE on the next edge, en=1, a and b hold, counter cleared.
- Restart from IDLE always begins at the lowest enabled digit.
- Reset mid-operation: en goes to 1 immediately (async), with no glitch to 0.
- Counter width: $clog2(max(PRESCALE, BLANK_CYC, 2)). No overflow is possible.
- tick never asserts while en=1.

Optional Feature:
- Macro: SCAN_SEQ_DIM_EN
- Defined:
  - Adds input dim (2 bits).
  - During DWELL, en=0 only for the first max(1, PRESCALE>>dim) cycles, then en=1 for the rest of the dwell.
  - The address is unchanged during that tail; total dwell length is unchanged.
  - dim is sampled at DWELL entry.
- Undefined: no dim port; en=0 for the whole dwell.

Decomposition:
- Package scan_seq_pkg:
  - NUM_DIG=4, SEL_W=2.
  - typedef enum state_t {IDLE, DWELL, BLANK}.
  - Function for the counter width.
- Sub-module next_dig_pick:
  - Purely combinational round-robin picker.
  - Inputs: mask, cur.
  - Outputs: nxt, valid (valid = mask!=0).
  - Used for both the restart (lowest set bit) and advance selections.

Test Plan:
All scenarios use PRESCALE=4, BLANK_CYC=1 unless noted.
1. Reset:
   - Stimulus: rst_n=0, then release with run=0 for 10 cycles.
   - Response: en=1, a=b=0, tick=0 throughout.
2. Full scan:
   - Stimulus: run=1, mask=4'b1111.
   - Response: {a,b} sequence 00,01,10,11,00. Each digit has en=0 for 4 cycles, then en=1 for 1 cycle. Period 20 cycles; tick every 5 cycles.
   - Checker: no address change while en=0.
3. Sparse mask:
   - Stimulus: mask=4'b1010.
   - Response: digits 1,3,1,3. Then change mask to 4'b0001 mid-dwell of digit 3; the next digit is 0.
4. Single digit, no gap:
   - Stimulus: mask=4'b0100, BLANK_CYC=0.
   - Response: {a,b}=10 constant, en=0 constant, tick every 4 cycles.
5. Stop and restart:
   - Stimulus: drop run in cycle 2 of the digit-2 dwell.
   - Response: next edge en=1, {a,b}=10 held. Re-raise run with mask=4'b1111; the scan restarts at digit 0 with 1-cycle latency.
6. Async reset:
   - Stimulus: rst_n=0 mid-dwell, between clock edges.
   - Response: en=1 and {a,b}=00 immediately, without a clock edge.
   - Dim (SCAN_SEQ_DIM_EN): dim=1 gives en=0 for 2 of 4 dwell cycles.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared widths, FSM state type and counter sizing for the scan sequencer.
`default_nettype none

package scan_seq_pkg;

  localparam int NUM_DIG = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Wide enough for both the dwell and the blank count, never below one bit.
  function automatic int cnt_width(input int prescale, input int blank_cyc);
    int m;
    m = 2;
    if (prescale > m) m = prescale;
    if (blank_cyc > m) m = blank_cyc;
    return $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_dig_pick.sv
// next_dig_pick: combinational round-robin search for the next set mask bit after cur.
`default_nettype none

module next_dig_pick
  import scan_seq_pkg::*;
(
  input  logic [NUM_DIG-1:0] mask,
  input  logic [SEL_W-1:0]   cur,
  output logic [SEL_W-1:0]   nxt,
  output logic               valid
);

  logic [SEL_W-1:0] probe;

  // Offsets are scanned from farthest to nearest so the nearest set bit wins;
  // if no other bit is set the current index is reused.
  always_comb begin
    nxt   = cur;
    valid = |mask;
    probe = '0;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      probe = cur + SEL_W'(i);
      if (mask[probe]) nxt = probe;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_sel_seq.sv
// scan_sel_seq: scans a 2-to-4 decoder round-robin with programmable dwell and blanking gap.
// Optional macro SCAN_SEQ_DIM_EN adds the dim input (shortened enable window). Rev 1.0
`default_nettype none

module scan_sel_seq
  import scan_seq_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [NUM_DIG-1:0] digit_mask,
`ifdef SCAN_SEQ_DIM_EN
  input  logic [1:0]         dim,
`endif
  output logic               a,
  output logic               b,
  output logic               en,
  output logic               tick,
  output logic [SEL_W-1:0]   cur_dig
);

  localparam int CW = cnt_width(PRESCALE, BLANK_CYC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] pick_cur;
  logic [SEL_W-1:0] pick_nxt;
  logic             pick_valid;
  logic             dim_off;

  // From IDLE the search starts after the top index so it lands on the lowest set bit.
  assign pick_cur = (state == IDLE) ? SEL_W'(NUM_DIG - 1) : idx;

  next_dig_pick u_pick (
    .mask  (digit_mask),
    .cur   (pick_cur),
    .nxt   (pick_nxt),
    .valid (pick_valid)
  );

`ifdef SCAN_SEQ_DIM_EN
  logic [1:0] dim_q;
  logic       enter_dwell;
  int         lit_len;

  assign enter_dwell = run &&
                       (((state == IDLE) && pick_valid) ||
                        ((state == DWELL) && (cnt == DWELL_LAST) && pick_valid && (BLANK_CYC == 0)) ||
                        ((state == BLANK) && (cnt == BLANK_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_q <= 2'd0;
    end else if (enter_dwell) begin
      dim_q <= dim;
    end
  end

  // en is released once the counter reaches the lit length; the address stays put.
  always_comb begin
    lit_len = PRESCALE >> dim_q;
    if (lit_len < 1) lit_len = 1;
    dim_off = (int'(cnt) + 1) >= lit_len;
  end
`else
  assign dim_off = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      en    <= 1'b1;
      tick  <= 1'b0;
      cnt   <= '0;
    end else begin
      tick <= 1'b0;
      if (!run) begin
        state <= IDLE;
        en    <= 1'b1;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              state <= DWELL;
              idx   <= pick_nxt;
              en    <= 1'b0;
              tick  <= 1'b1;
              cnt   <= '0;
            end
          end
          DWELL: begin
            if (cnt == DWELL_LAST) begin
              cnt <= '0;
              if (!pick_valid) begin
                state <= IDLE;
                en    <= 1'b1;
              end else if (BLANK_CYC > 0) begin
                state <= BLANK;
                en    <= 1'b1;
                idx   <= pick_nxt;
              end else begin
                idx   <= pick_nxt;
                en    <= 1'b0;
                tick  <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
              en  <= dim_off;
            end
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= DWELL;
              en    <= 1'b0;
              tick  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            en    <= 1'b1;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign a       = idx[1];
  assign b       = idx[0];
  assign cur_dig = idx;

endmodule

`default_nettype wire

// File: tb/tb_scan_sel_seq.sv
// tb_scan_sel_seq: directed vector table plus hand-written corner sequences for scan_sel_seq.
`default_nettype none

module tb_scan_sel_seq;

  typedef struct packed {
    logic       run;
    logic [3:0] mask;
    logic [1:0] dig;
    logic       en;
    logic       tick;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       run0, run1;
  logic [3:0] mask0, mask1;
  logic       a0, b0, en0, tick0;
  logic       a1, b1, en1, tick1;
  logic [1:0] dig0, dig1;
  logic [1:0] dim;

  int checks;
  int errors;

  vec_t vt[$];

  scan_sel_seq #(.PRESCALE(4), .BLANK_CYC(1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run0),
    .digit_mask (mask0),
`ifdef SCAN_SEQ_DIM_EN
    .dim        (dim),
`endif
    .a          (a0),
    .b          (b0),
    .en         (en0),
    .tick       (tick0),
    .cur_dig    (dig0)
  );

  scan_sel_seq #(.PRESCALE(4), .BLANK_CYC(0)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run1),
    .digit_mask (mask1),
`ifdef SCAN_SEQ_DIM_EN
    .dim        (2'd0),
`endif
    .a          (a1),
    .b          (b1),
    .en         (en1),
    .tick       (tick1),
    .cur_dig    (dig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] m, input logic [1:0] d,
                              input logic e, input logic t);
    vec_t v;
    v.run = r; v.mask = m; v.dig = d; v.en = e; v.tick = t;
    vt.push_back(v);
  endfunction

  // Continuous properties: address frozen while the decoder is enabled, no tick while blanked.
  logic       prev_en0;
  logic [1:0] prev_dig0;
  initial begin
    prev_en0  = 1'b1;
    prev_dig0 = 2'd0;
  end
  always @(negedge clk) begin
    if (rst_n && !prev_en0 && !en0) chk("addr_stable_while_en0", dig0, prev_dig0);
    if (tick0) chk("tick_with_en_dut0", en0, 0);
    if (tick1) chk("tick_with_en_dut1", en1, 0);
    prev_en0  = en0;
    prev_dig0 = dig0;
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    run0   = 1'b0; mask0 = 4'h0;
    run1   = 1'b0; mask1 = 4'h0;
    dim    = 2'd0;

    // Full scan 0,1,2,3 then back to 0: dwell 4 cycles, blank 1 cycle.
    for (int d = 0; d < 4; d++) begin
      add(1, 4'hF, 2'(d), 0, 1);
      add(1, 4'hF, 2'(d), 0, 0);
      add(1, 4'hF, 2'(d), 0, 0);
      add(1, 4'hF, 2'(d), 0, 0);
      add(1, 4'hF, 2'((d + 1) % 4), 1, 0);
    end
    add(1, 4'hF, 0, 0, 1);
    // Sparse mask 1010 picked at the next boundary: 1,3,1,3.
    add(1, 4'hA, 0, 0, 0); add(1, 4'hA, 0, 0, 0); add(1, 4'hA, 0, 0, 0);
    add(1, 4'hA, 1, 1, 0);
    add(1, 4'hA, 1, 0, 1); add(1, 4'hA, 1, 0, 0); add(1, 4'hA, 1, 0, 0); add(1, 4'hA, 1, 0, 0);
    add(1, 4'hA, 3, 1, 0);
    add(1, 4'hA, 3, 0, 1); add(1, 4'hA, 3, 0, 0); add(1, 4'hA, 3, 0, 0); add(1, 4'hA, 3, 0, 0);
    add(1, 4'hA, 1, 1, 0);
    add(1, 4'hA, 1, 0, 1); add(1, 4'hA, 1, 0, 0); add(1, 4'hA, 1, 0, 0); add(1, 4'hA, 1, 0, 0);
    add(1, 4'hA, 3, 1, 0);
    add(1, 4'hA, 3, 0, 1);
    // Mask becomes 0001 mid-dwell of digit 3: next digit is 0.
    add(1, 4'h1, 3, 0, 0); add(1, 4'h1, 3, 0, 0); add(1, 4'h1, 3, 0, 0);
    add(1, 4'h1, 0, 1, 0);
    add(1, 4'h1, 0, 0, 1); add(1, 4'h1, 0, 0, 0); add(1, 4'h1, 0, 0, 0); add(1, 4'h1, 0, 0, 0);
    // Only the current bit set: same index, blank and tick still happen.
    add(1, 4'h1, 0, 1, 0);
    add(1, 4'h1, 0, 0, 1);
    // Mask cleared: IDLE at the next selection, address held.
    add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0); add(1, 4'h0, 0, 0, 0);
    add(1, 4'h0, 0, 1, 0);
    add(1, 4'h0, 0, 1, 0);
    // Start on digit 2, drop run in its second dwell cycle, restart at digit 0.
    add(1, 4'h4, 2, 0, 1);
    add(1, 4'h4, 2, 0, 0);
    add(0, 4'h4, 2, 1, 0);
    add(0, 4'hF, 2, 1, 0);
    add(1, 4'hF, 0, 0, 1);
    add(0, 4'hF, 0, 1, 0);

    // Reset state, held and after release with run=0.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en0, 1);
    chk("rst_dig", dig0, 0);
    chk("rst_tick", tick0, 0);
    chk("rst_en_dut1", en1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_en", en0, 1);
      chk("idle_ab", {a0, b0}, 0);
      chk("idle_tick", tick0, 0);
    end

    // Table-driven main function on the gapped instance.
    foreach (vt[i]) begin
      run0  = vt[i].run;
      mask0 = vt[i].mask;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dig", i), dig0, vt[i].dig);
      chk($sformatf("vec%0d_ab", i), {a0, b0}, vt[i].dig);
      chk($sformatf("vec%0d_en", i), en0, vt[i].en);
      chk($sformatf("vec%0d_tick", i), tick0, vt[i].tick);
    end

    // Single digit with no blanking: constant address, en held low, tick every 4 cycles.
    run1  = 1'b1;
    mask1 = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("nogap_dig", dig1, 2);
      chk("nogap_en", en1, 0);
      chk("nogap_tick", tick1, (i % 4 == 0) ? 1 : 0);
    end
    run1 = 1'b0;

    // Asynchronous reset mid-dwell, between edges.
    run0  = 1'b1;
    mask0 = 4'b1000;
    @(posedge clk); #1;
    chk("pre_arst_dig", dig0, 3);
    chk("pre_arst_en", en0, 0);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", en0, 1);
    chk("arst_dig", dig0, 0);
    chk("arst_tick", tick0, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("arst_hold_en", en0, 1);
    end
    rst_n = 1'b1;
    run0  = 1'b0;
    @(posedge clk); #1;

`ifdef SCAN_SEQ_DIM_EN
    // dim=1: en low for 2 of the 4 dwell cycles, then the blank.
    dim   = 2'd1;
    run0  = 1'b1;
    mask0 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("dim_en", en0, (i < 2) ? 0 : 1);
      chk("dim_dig", dig0, 0);
    end
    run0 = 1'b0;
    dim  = 2'd0;
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
